// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux scan sequencer.
// The MUX_SCAN_CONT_EN macro selects continuous scanning in mux_scan_ctrl.
`timescale 1ns/1ps
package mux_scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_SEL_W  = 2;
    localparam int DEF_DWELL  = 2;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // DWELL=1 still needs a one-bit counter that simply stays at zero
    function automatic int cnt_w(input int dwell);
        return (clog2(dwell) < 1) ? 1 : clog2(dwell);
    endfunction

endpackage

// File: rtl/mux_scan_dwell_cnt.sv
// Loadable down-counter timing the settle period on each channel.
`timescale 1ns/1ps
module mux_scan_dwell_cnt #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Steps a 4:1 mux select through every channel and captures y into a word.
// Define MUX_SCAN_CONT_EN for continuous scanning with a stop input.
`timescale 1ns/1ps
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int SEL_W  = DEF_SEL_W,
    parameter int DWELL  = DEF_DWELL
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
`ifdef MUX_SCAN_CONT_EN
    input  logic              stop,
`endif
    input  logic              y,
    output logic [SEL_W-1:0]  sel,
    output logic              busy,
    output logic [NUM_CH-1:0] word,
    output logic              word_valid,
    input  logic              word_ready
);

    localparam int CW = cnt_w(DWELL);
    localparam logic [CW-1:0] RELOAD = CW'(DWELL - 1);
    localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_CH - 1);

    state_t state, state_nx;

    logic              cnt_load;
    logic              cnt_en;
    logic              cnt_zero;
    logic              go;
    logic              capture;
    logic              finish;
    logic              done;
    logic [NUM_CH-1:0] shadow;
    logic [NUM_CH-1:0] merged;

`ifdef MUX_SCAN_CONT_EN
    logic stop_q;
    logic stop_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stop_q    <= 1'b0;
            stop_pend <= 1'b0;
        end else begin
            stop_q <= stop;
            if (stop && !stop_q) begin
                stop_pend <= 1'b1;
            end else if (done) begin
                stop_pend <= 1'b0;
            end
        end
    end
`endif

    mux_scan_dwell_cnt #(
        .W (CW)
    ) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .en       (cnt_en),
        .load_val (RELOAD),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        go       = 1'b0;
        capture  = 1'b0;
        finish   = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = SETTLE;
                    cnt_load = 1'b1;
                    go       = 1'b1;
                end
            end
            SETTLE: begin
                if (!cnt_zero) begin
                    cnt_en = 1'b1;
                end else begin
                    capture = 1'b1;
                    if (sel != LAST) begin
                        cnt_load = 1'b1;
                    end else begin
                        finish   = 1'b1;
                        state_nx = HOLD;
                    end
                end
            end
            HOLD: begin
                if (word_ready) begin
                    done     = 1'b1;
                    state_nx = IDLE;
`ifdef MUX_SCAN_CONT_EN
                    if (!stop_pend) begin
                        state_nx = SETTLE;
                        cnt_load = 1'b1;
                        go       = 1'b1;
                    end
`endif
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        merged      = shadow;
        merged[sel] = y;
    end

    // go follows done so a continuous restart keeps busy high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel        <= '0;
            busy       <= 1'b0;
            word       <= '0;
            word_valid <= 1'b0;
            shadow     <= '0;
        end else begin
            if (done) begin
                word_valid <= 1'b0;
                busy       <= 1'b0;
                sel        <= '0;
            end
            if (go) begin
                sel    <= '0;
                busy   <= 1'b1;
                shadow <= '0;
            end
            if (capture) begin
                shadow[sel] <= y;
                if (sel != LAST) begin
                    sel <= sel + 1'b1;
                end
            end
            if (finish) begin
                word       <= merged;
                word_valid <= 1'b1;
            end
        end
    end

endmodule
